neopixel_tx_encoder: RTL and testbench

Read-side consumer of the 24-bit pixel FIFO in the neopixel transmitter. It pops GRB words, serializes them MSB-first into WS2812 one-wire timing, and closes each frame with a low latch (reset) period. It sits between the pixel FIFO (dataOut/empty_flg/rd_en) and the output pin.

---
 rtl/neopixel_pkg.sv | 25 ++
 rtl/neopixel_bit_timer.sv | 29 ++
 rtl/neopixel_tx_encoder.sv | 149 ++++++++++++++
 tb/tb_neopixel_tx_encoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared types and defaults for the WS2812 transmit encoder.
//   state_t          encoder FSM states (IDLE/HIGH/LOW/LATCH)
//   *_CYC_DEF        default timing constants for a 50 MHz clock
//   NEOPIXEL_WORD_W  GRB pixel word width
package neopixel_pkg;

   localparam int NEOPIXEL_WORD_W = 24;

   localparam int T0H_CYC_DEF    = 20;    // 400 ns
   localparam int T1H_CYC_DEF    = 40;    // 800 ns
   localparam int TBIT_CYC_DEF   = 63;    // ~1.26 us
   localparam int TRESET_CYC_DEF = 2500;  // 50 us

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      LATCH = 2'd3
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/neopixel_bit_timer.sv
// neopixel_bit_timer: loadable down-counter shared by the HIGH, LOW and LATCH
// phases. Loading N-1 makes the phase last N cycles; expire is high in the
// last cycle of the phase (count at zero). The count holds at zero and never
// wraps.
//   clk, rst   clock, async active-low reset
//   load       load strobe (wins over counting)
//   load_val   value loaded (phase length - 1)
//   expire     count is zero
module neopixel_bit_timer #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/neopixel_tx_encoder.sv
// neopixel_tx_encoder: pops GRB words from the pixel FIFO and serialises them
// MSB first in WS2812 one-wire timing, closing each frame with a low latch
// period followed by a one-cycle frame_done pulse.
//   clk, rst      clock, async active-low reset
//   fifo_data     FIFO head word, valid while fifo_empty=0
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    registered one-cycle pop strobe per word
//   tx_en         allows a frame or the next word to start
//   dout          serial data (registered)
//   busy          high outside IDLE
//   frame_done    registered pulse after the latch period
// Build option: NEOPIXEL_OUT_INVERT_EN inverts dout (reset/idle level 1) for
// inverting level shifters; timing is unchanged.
module neopixel_tx_encoder
   import neopixel_pkg::*;
#(
   parameter int U_WORD_WIDTH = NEOPIXEL_WORD_W,
   parameter int T0H_CYC      = T0H_CYC_DEF,
   parameter int T1H_CYC      = T1H_CYC_DEF,
   parameter int TBIT_CYC     = TBIT_CYC_DEF,
   parameter int TRESET_CYC   = TRESET_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [U_WORD_WIDTH-1:0] fifo_data,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   input  logic                    tx_en,
   output logic                    dout,
   output logic                    busy,
   output logic                    frame_done
);

   if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC &&
         TRESET_CYC >= 1 && U_WORD_WIDTH >= 2)) begin : g_param_chk
      $fatal(1, "neopixel_tx_encoder: illegal timing parameters");
   end

   localparam int CNT_W = $clog2(max2(TBIT_CYC, TRESET_CYC) + 1);
   localparam int IDX_W = max2($clog2(U_WORD_WIDTH), 1);

   // Timer load values are phase length - 1.
   localparam logic [CNT_W-1:0] LD_H0  = CNT_W'(T0H_CYC - 1);
   localparam logic [CNT_W-1:0] LD_H1  = CNT_W'(T1H_CYC - 1);
   localparam logic [CNT_W-1:0] LD_L0  = CNT_W'(TBIT_CYC - T0H_CYC - 1);
   localparam logic [CNT_W-1:0] LD_L1  = CNT_W'(TBIT_CYC - T1H_CYC - 1);
   localparam logic [CNT_W-1:0] LD_RST = CNT_W'(TRESET_CYC - 1);

`ifdef NEOPIXEL_OUT_INVERT_EN
   localparam logic DOUT_IDLE = 1'b1;
`else
   localparam logic DOUT_IDLE = 1'b0;
`endif

   state_t                  state, nxt_state;
   logic [U_WORD_WIDTH-1:0] shift_reg;
   logic [IDX_W-1:0]        bit_idx;
   logic                    tmr_load, tmr_exp;
   logic [CNT_W-1:0]        tmr_val;
   logic                    can_load, load_word, shift;

   neopixel_bit_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_exp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      load_word = 1'b0;
      shift     = 1'b0;
      can_load  = tx_en && !fifo_empty;
      case (state)
         IDLE: begin
            if (can_load) begin
               load_word = 1'b1;
               nxt_state = HIGH;
               tmr_load  = 1'b1;
               tmr_val   = fifo_data[U_WORD_WIDTH-1] ? LD_H1 : LD_H0;
            end
         end
         HIGH: begin
            if (tmr_exp) begin
               nxt_state = LOW;
               tmr_load  = 1'b1;
               tmr_val   = shift_reg[U_WORD_WIDTH-1] ? LD_L1 : LD_L0;
            end
         end
         LOW: begin
            if (tmr_exp) begin
               tmr_load = 1'b1;
               if (bit_idx != '0) begin
                  // High time of the next bit comes from the bit about to
                  // become the MSB.
                  shift     = 1'b1;
                  nxt_state = HIGH;
                  tmr_val   = shift_reg[U_WORD_WIDTH-2] ? LD_H1 : LD_H0;
               end else if (can_load) begin
                  // Back-to-back word: no gap after the last low cycle.
                  load_word = 1'b1;
                  nxt_state = HIGH;
                  tmr_val   = fifo_data[U_WORD_WIDTH-1] ? LD_H1 : LD_H0;
               end else begin
                  nxt_state = LATCH;
                  tmr_val   = LD_RST;
               end
            end
         end
         LATCH: begin
            if (tmr_exp) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg  <= '0;
         bit_idx    <= '0;
         fifo_rd_en <= 1'b0;
         frame_done <= 1'b0;
         dout       <= DOUT_IDLE;
      end else begin
         fifo_rd_en <= load_word;
         frame_done <= (state == LATCH) && tmr_exp;
         // Registered from next state so dout lines up with the HIGH state.
         dout       <= (nxt_state == HIGH) ^ DOUT_IDLE;
         if (load_word) begin
            shift_reg <= fifo_data;
            bit_idx   <= IDX_W'(U_WORD_WIDTH - 1);
         end else if (shift) begin
            shift_reg <= shift_reg << 1;
            bit_idx   <= bit_idx - 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_neopixel_tx_encoder.sv
// Bench for neopixel_tx_encoder with short timing (T0H=2, T1H=4, TBIT=6,
// TRESET=10). The reference model expands the transmitted words into the
// expected per-cycle {dout, fifo_rd_en, frame_done, busy} trace from the
// WS2812 bit rules; a queue models the FIFO, advancing on each rd_en rise.
module tb_neopixel_tx_encoder;

   localparam int W    = 24;
   localparam int T0H  = 2;
   localparam int T1H  = 4;
   localparam int TBIT = 6;
   localparam int TRST = 10;

`ifdef NEOPIXEL_OUT_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tx_en = 1'b0;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_data = '0;
   logic         fifo_rd_en, dout, busy, frame_done;

   int vec  = 0;
   int bad  = 0;
   int pops = 0;

   logic [W-1:0] fq[$];   // FIFO contents
   logic [W-1:0] wl[$];   // words expected on the wire for the next frame
   logic [3:0]   eq[$];   // expected {dout, rd_en, frame_done, busy} per cycle

   always #5 clk = ~clk;

   neopixel_tx_encoder #(
      .U_WORD_WIDTH (W),
      .T0H_CYC      (T0H),
      .T1H_CYC      (T1H),
      .TBIT_CYC     (TBIT),
      .TRESET_CYC   (TRST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .tx_en      (tx_en),
      .dout       (dout),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic fifo_upd();
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? '0 : fq[0];
   endtask

   always @(posedge fifo_rd_en) begin
      pops++;
      if (fq.size() > 0) void'(fq.pop_front());
      fifo_upd();
   end

   // Expand wl into the cycle trace: each bit is THx high then TBIT-THx low,
   // rd_en in the first cycle of each word, TRST latch cycles, then the
   // frame_done cycle back in IDLE.
   task automatic build();
      eq.delete();
      foreach (wl[i]) begin
         for (int b = W - 1; b >= 0; b--) begin
            int hi;
            hi = wl[i][b] ? T1H : T0H;
            for (int c = 0; c < TBIT; c++)
               eq.push_back({(c < hi) ^ INV, (b == W - 1 && c == 0), 1'b0, 1'b1});
         end
      end
      repeat (TRST) eq.push_back({INV, 1'b0, 1'b0, 1'b1});
      eq.push_back({INV, 1'b0, 1'b1, 1'b0});
   endtask

   // Check up to ncyc expected cycles (all if ncyc<0); drop tx_en after
   // cycle drop_at.
   task automatic run(input string tag, input int ncyc, input int drop_at);
      int n;
      n = 0;
      while (eq.size() > 0 && (ncyc < 0 || n < ncyc)) begin
         @(negedge clk);
         chk(tag, 32'({dout, fifo_rd_en, frame_done, busy}), 32'(eq.pop_front()));
         if (n == drop_at) tx_en = 1'b0;
         n++;
      end
   endtask

   task automatic idle_chk(input string tag, input int ncyc);
      repeat (ncyc) begin
         @(negedge clk);
         chk(tag, 32'({dout, fifo_rd_en, frame_done, busy}), 32'({INV, 3'b000}));
      end
   endtask

   // Queue wl (plus n_extra random words behind it), enable, check the frame
   // and the number of pops.
   task automatic frame(input string tag, input int drop_at, input int n_extra);
      int p0;
      foreach (wl[i]) fq.push_back(wl[i]);
      repeat (n_extra) fq.push_back(W'($urandom));
      fifo_upd();
      tx_en = 1'b1;
      build();
      p0 = pops;
      run(tag, -1, drop_at);
      chk({tag, "_pops"}, 32'(pops - p0), 32'(wl.size()));
      chk({tag, "_left"}, 32'(fq.size()), 32'(n_extra));
   endtask

   initial begin
      fifo_upd();
      #1 rst = 1'b0;
      #1;
      chk("rst_dout",  32'(dout),       32'(INV));
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_fdone", 32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle_chk("idle0", 2);

      // Single word, mixed bit pattern.
      wl = '{24'hA50000};
      frame("s1", -1, 0);

      // Two back-to-back words: no gap at the word boundary.
      wl = '{24'hFFFFFF, 24'h000000};
      frame("s2", -1, 0);

      // Enabled with an empty FIFO stays idle; then a word starts one cycle
      // after empty falls.
      tx_en = 1'b1;
      idle_chk("s3_idle", 20);
      wl = '{W'($urandom)};
      frame("s3", -1, 0);

      // tx_en dropped during bit 10: word completes, next word stays queued.
      wl = '{W'($urandom)};
      frame("s4", 10 * TBIT + 1, 1);
      idle_chk("s4_idle", 3);

      // Reset during the high phase of bit 5 aborts the word at once.
      fq.push_back(W'($urandom));
      fifo_upd();
      wl = '{fq[0]};
      build();
      tx_en = 1'b1;
      run("s5_pre", 5 * TBIT + 1, -1);
      #1 rst = 1'b0;
      #1;
      chk("s5_rst_dout",  32'(dout),       32'(INV));
      chk("s5_rst_busy",  32'(busy),       32'd0);
      chk("s5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      chk("s5_rst_hold", 32'({dout, fifo_rd_en, frame_done, busy}), 32'({INV, 3'b000}));
      @(negedge clk);
      rst = 1'b1;
      wl = '{fq[0]};
      fq.delete();
      frame("s5", -1, 0);

      // Random frames of 1..3 words separated by short idle gaps.
      for (int k = 0; k < 6; k++) begin
         int n;
         tx_en = 1'b0;
         idle_chk("rnd_idle", int'($urandom_range(1, 4)));
         n = int'($urandom_range(1, 3));
         wl.delete();
         repeat (n) wl.push_back(W'($urandom));
         frame("rnd", -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
